// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: decodes a PWM line into per-period high/period counts, flags off-nominal
// periods and stuck lines. Optional glitch filter enabled by defining PWM_GLITCH_FILTER_EN.
module pwm_duty_decoder #(
  parameter int unsigned CW         = 16,
  parameter int unsigned NOM_PERIOD = 10,
  parameter int unsigned PERIOD_TOL = 0,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned FILT_LEN   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwm_in,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period_cnt,
  output logic          meas_valid,
  output logic          period_err,
  output logic          stuck_low,
  output logic          stuck_high,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int unsigned   EW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] SAT       = '1;
  localparam logic [EW-1:0] ECNT_LAST = EW'(TIMEOUT - 1);
  localparam int unsigned   HI_LIM    = NOM_PERIOD + PERIOD_TOL;
  localparam int unsigned   LO_LIM    = (NOM_PERIOD > PERIOD_TOL) ? NOM_PERIOD - PERIOD_TOL : 0;

  if (FILT_LEN == 0) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end
  if (TIMEOUT <= NOM_PERIOD) begin : g_bad_timeout
    $error("TIMEOUT must exceed NOM_PERIOD");
  end

  // meas_valid is a single-cycle strobe with no backpressure: a consumer that
  // misses it can still read the held outputs until the next strobe.

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == SAT) ? v : v + 1'b1;
  endfunction

  function automatic logic period_off(input logic [CW-1:0] p);
    return (32'(p) > HI_LIM) || (32'(p) < LO_LIM) || (p == SAT);
  endfunction

  logic          s1_q, s1_d, s2_q, s2_d;
  logic          lvl, lvl_prev_q, lvl_prev_d;
  logic          rise, fall, edge_seen, timeout;
  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic          to_done_q, to_done_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic          meas_valid_q, meas_valid_d, period_err_q, period_err_d;
  logic          stuck_low_q, stuck_low_d, stuck_high_q, stuck_high_d;

`ifdef PWM_GLITCH_FILTER_EN
  // Filtered level moves only after FILT_LEN consecutive samples disagree with it.
  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  logic          flt_q, flt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    flt_d  = flt_q;
    fcnt_d = '0;
    if (s2_q != flt_q) begin
      if (32'(fcnt_q) + 32'd1 >= FILT_LEN) flt_d = s2_q;
      else                                 fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flt_q  <= 1'b0;
      fcnt_q <= '0;
    end else begin
      flt_q  <= flt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = flt_q;
`else
  assign lvl = s2_q;
`endif

  assign rise      = lvl & ~lvl_prev_q;
  assign fall      = ~lvl & lvl_prev_q;
  assign edge_seen = rise | fall;
  // An edge in the same cycle as the timeout wins; to_done_q stops repeats while stuck.
  assign timeout   = (ecnt_q == ECNT_LAST) && !edge_seen && !to_done_q;

  always_comb begin
    s1_d          = pwm_in;
    s2_d          = s1_q;
    lvl_prev_d    = lvl;
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    pcnt_d        = pcnt_q;
    ecnt_d        = ecnt_q;
    to_done_d     = to_done_q;
    high_cnt_d    = high_cnt_q;
    period_cnt_d  = period_cnt_q;
    period_err_d  = period_err_q;
    stuck_low_d   = stuck_low_q;
    stuck_high_d  = stuck_high_q;
    meas_valid_d  = 1'b0;

    if (edge_seen) begin
      ecnt_d    = '0;
      to_done_d = 1'b0;
    end else if (ecnt_q != ECNT_LAST) begin
      ecnt_d = ecnt_q + 1'b1;
    end

    if (timeout) begin
      state_d      = IDLE;
      to_done_d    = 1'b1;
      stuck_low_d  = ~lvl;
      stuck_high_d = lvl;
      high_cnt_d   = lvl ? CW'(NOM_PERIOD) : '0;
      period_cnt_d = CW'(NOM_PERIOD);
      period_err_d = 1'b0;
      meas_valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            hcnt_d  = CW'(1);
            pcnt_d  = CW'(1);
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            pcnt_d  = sat_inc(pcnt_q);
          end else begin
            hcnt_d = sat_inc(hcnt_q);
            pcnt_d = sat_inc(pcnt_q);
          end
        end
        LOW: begin
          if (rise) begin
            high_cnt_d   = hcnt_q;
            period_cnt_d = pcnt_q;
            period_err_d = period_off(pcnt_q);
            stuck_low_d  = 1'b0;
            stuck_high_d = 1'b0;
            meas_valid_d = 1'b1;
            state_d      = HIGH;
            hcnt_d       = CW'(1);
            pcnt_d       = CW'(1);
          end else begin
            pcnt_d = sat_inc(pcnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      lvl_prev_q   <= 1'b0;
      state_q      <= IDLE;
      hcnt_q       <= '0;
      pcnt_q       <= '0;
      ecnt_q       <= '0;
      to_done_q    <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      stuck_low_q  <= 1'b0;
      stuck_high_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      lvl_prev_q   <= lvl_prev_d;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      pcnt_q       <= pcnt_d;
      ecnt_q       <= ecnt_d;
      to_done_q    <= to_done_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      period_err_q <= period_err_d;
      stuck_low_q  <= stuck_low_d;
      stuck_high_q <= stuck_high_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = meas_valid_q;
  assign period_err = period_err_q;
  assign stuck_low  = stuck_low_q;
  assign stuck_high = stuck_high_q;
  assign dbg_state  = state_q;

endmodule
